word_packer: RTL



---
 rtl/ec_pkg.sv | 15 +
 rtl/word_packer_parity_accum.sv | 24 ++
 rtl/word_packer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ec_pkg.sv
// Shared definitions for the frame packer: FSM encoding and count-width helper.
package ec_pkg;

  // FILL collects words, HOLD presents a completed frame downstream.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bits needed to hold a word count 0..n (used for idx and out_count).
  function automatic int count_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/word_packer_parity_accum.sv
// parity_accum: width-bit running XOR with clear/seed/enable controls.
// Priority: rst > seed > clr > en. Seed loads the incoming word directly,
// which starts a new frame whose first word arrives with the emission.
module parity_accum #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             seed,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] acc
);

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst)       acc <= '0;
    else if (seed) acc <= d;
    else if (clr)  acc <= '0;
    else if (en)   acc <= acc ^ d;
  end

endmodule

// File: rtl/word_packer.sv
// word_packer: serial-to-parallel frame packer feeding the column-XOR stage.
// Collects up to n words of width bits into a flat bus, zero-pads short
// frames (ended early by in_last) and holds each frame until accepted.
// Optional: define WORD_PACKER_PARITY_EN to add out_parity, the column XOR
// of the words in the held frame.
module word_packer
  import ec_pkg::*;
#(
  parameter int width = 1,
  parameter int n     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [width-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [width*n-1:0]         out_flat,
  output logic [count_w(n)-1:0]      out_count,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef WORD_PACKER_PARITY_EN
  , output logic [width-1:0]         out_parity
`endif
);

  localparam int CW = count_w(n);
  localparam logic [CW-1:0] LAST_IDX = CW'(n - 1);

  state_t                    state, state_nxt;
  logic [CW-1:0]             idx, idx_nxt;
  logic [CW-1:0]             cnt_nxt;
  logic [n-1:0][width-1:0]   slots;

  logic          in_hs, out_hs;
  logic [CW-1:0] wr_idx;   // slot targeted by an accepted word
  logic          done;     // accepted word completes the frame
  logic          wr, clr;

  assign out_valid = (state == HOLD);
  // Only combinational path: in HOLD the packer can take a word only when
  // the held frame leaves in the same cycle.
  assign in_ready  = (state == FILL) ? 1'b1 : out_ready;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  // A word accepted during HOLD always starts the next frame at slot 0.
  assign wr_idx    = (state == HOLD) ? '0 : idx;
  assign done      = (wr_idx == LAST_IDX) || in_last;
  assign out_flat  = slots;

  // Next-state, slot write/clear and count decisions.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = out_count;
    wr        = 1'b0;
    clr       = 1'b0;
    case (state)
      FILL: begin
        if (in_hs) begin
          wr = 1'b1;
          if (done) begin
            state_nxt = HOLD;
            cnt_nxt   = CW'(wr_idx + 1'b1);
            idx_nxt   = '0;
          end else begin
            idx_nxt   = CW'(wr_idx + 1'b1);
          end
        end
      end
      HOLD: begin
        if (out_hs) begin
          clr     = 1'b1;
          cnt_nxt = '0;
          if (in_hs) begin
            wr = 1'b1;
            if (done) begin
              state_nxt = HOLD;
              cnt_nxt   = CW'(1);
              idx_nxt   = '0;
            end else begin
              state_nxt = FILL;
              idx_nxt   = CW'(1);
            end
          end else begin
            state_nxt = FILL;
            idx_nxt   = '0;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // State, index and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      out_count <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      out_count <= cnt_nxt;
    end
  end

  // Frame buffer: cleared on emission, then the new word (if any) lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (wr && (wr_idx == CW'(k)))
          slots[k] <= in_data;
        else if (clr)
          slots[k] <= '0;
      end
    end
  end

`ifdef WORD_PACKER_PARITY_EN
  // Running parity follows the same clear/reseed rules as the slots.
  parity_accum #(
    .width (width)
  ) u_parity (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr && !wr),
    .seed (clr && wr),
    .en   (wr && !clr),
    .d    (in_data),
    .acc  (out_parity)
  );
`endif

endmodule
